// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands are held stable for an op-dependent number of cycles before the result is captured.
module alu_arbiter #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [2:0]      req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_zero,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_zero,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [2:0]      alu_op_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            busy
);

    localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;

    logic            gnt0, gnt1, rsp_hs;
    logic [2:0]      sel_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    // Only one requester may win; on contention the prio holder does.
    assign gnt0   = req0_valid & (~req1_valid | ~prio_q);
    assign gnt1   = req1_valid & (~req0_valid |  prio_q);
    assign sel_op = gnt1 ? req1_op : req0_op;
    assign rsp_hs = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    rs1_d   = gnt1 ? req1_rs1 : req0_rs1;
                    rs2_d   = gnt1 ? req1_rs2 : req0_rs2;
                    op_d    = sel_op;
                    case (sel_op)
                        3'b010:  cnt_d = CW'(DIV_CYCLES);
                        3'b011:  cnt_d = CW'(MUL_CYCLES);
                        default: cnt_d = CW'(1);
                    endcase
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CW'(1)) begin
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready  = (state_q == IDLE) & gnt0;
    assign req1_ready  = (state_q == IDLE) & gnt1;
    assign rsp0_valid  = (state_q == RESP) & ~owner_q;
    assign rsp1_valid  = (state_q == RESP) &  owner_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;
    assign alu_op_ctrl = op_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
// The bench also plays the role of the shared ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] req0_rs1 = 0, req0_rs2 = 0, req1_rs1 = 0, req1_rs2 = 0;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy;
    logic [31:0] rsp0_result, rsp1_result, alu_rs1, alu_rs2, alu_result;
    logic [2:0]  alu_op_ctrl;
    logic        alu_zero;

    alu_arbiter #(.XLEN(32), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op_ctrl(alu_op_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b011:  return a * b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int lat(logic [2:0] op);
        case (op)
            3'b010:  return 4;
            3'b011:  return 2;
            default: return 1;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_rs1, alu_rs2, alu_op_ctrl);
    assign alu_zero   = (alu_result == 32'd0);

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requester intent and the model of the op in flight
    logic [31:0] d_a[2], d_b[2];
    logic [2:0]  d_op[2];
    bit          d_pend[2], d_rdy[2];
    bit          m_act, m_own, m_prio;
    int          m_rem;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    bit          h_evt, h_who, g_evt, g_who;
    logic [31:0] h_res;
    logic        h_zero;

    task automatic cycle();
        bit g0, g1;
        @(negedge clk);
        req0_valid = d_pend[0]; req0_rs1 = d_a[0]; req0_rs2 = d_b[0]; req0_op = d_op[0];
        req1_valid = d_pend[1]; req1_rs1 = d_a[1]; req1_rs2 = d_b[1]; req1_op = d_op[1];
        rsp0_ready = d_rdy[0];  rsp1_ready = d_rdy[1];
        #1;
        g0 = !m_act && d_pend[0] && (!d_pend[1] || !m_prio);
        g1 = !m_act && d_pend[1] && (!d_pend[0] ||  m_prio);
        chk("ready0", 32'(req0_ready), 32'(g0));
        chk("ready1", 32'(req1_ready), 32'(g1));
        chk("busy", 32'(busy), 32'(m_act));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_act && m_rem == 0 && !m_own));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_act && m_rem == 0 &&  m_own));
        h_evt = 0;
        g_evt = 0;
        if (m_act) begin
            chk("alu_rs1", alu_rs1, m_a);
            chk("alu_rs2", alu_rs2, m_b);
            chk("alu_op", 32'(alu_op_ctrl), 32'(m_op));
        end
        if (m_act && m_rem == 0) begin
            chk("result", m_own ? rsp1_result : rsp0_result, m_res);
            chk("zero", 32'(m_own ? rsp1_zero : rsp0_zero), 32'(m_res == 0));
            if (d_rdy[m_own]) begin
                h_evt  = 1;
                h_who  = m_own;
                h_res  = m_own ? rsp1_result : rsp0_result;
                h_zero = m_own ? rsp1_zero : rsp0_zero;
            end
        end
        // advance the model across the coming rising edge
        if (g0 || g1) begin
            g_evt = 1; g_who = g1;
            m_act = 1; m_own = g1;
            m_a = d_a[g1]; m_b = d_b[g1]; m_op = d_op[g1];
            m_rem = lat(m_op);
            m_res = ref_alu(m_a, m_b, m_op);
            d_pend[g1] = 0;
        end else if (m_act && m_rem > 0) begin
            m_rem--;
        end else if (m_act && d_rdy[m_own]) begin
            m_act  = 0;
            m_prio = !m_own;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        d_pend[0] = 0; d_pend[1] = 0;
        req0_valid = 0; req1_valid = 0;
        rst_n = 0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'({req0_ready, req1_ready}), 0);
        chk("rst_rspv", 32'({rsp0_valid, rsp1_valid}), 0);
        chk("rst_res", rsp0_result, 0);
        chk("rst_zero", 32'(rsp1_zero), 0);
        chk("rst_alu", alu_rs1 | alu_rs2 | 32'(alu_op_ctrl), 0);
        m_act = 0; m_prio = 0; m_rem = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_req(input bit w, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        d_pend[w] = 1; d_a[w] = a; d_b[w] = b; d_op[w] = op;
    endtask

    task automatic wait_hs(input bit who);
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (h_evt) break;
        end
        chk("hs_seen", 32'(h_evt), 1);
        chk("hs_who", 32'(h_who), 32'(who));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            d_a[i] = 0; d_b[i] = 0; d_op[i] = 0; d_pend[i] = 0; d_rdy[i] = 1;
        end
        m_act = 0; m_own = 0; m_prio = 0; m_rem = 0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0;
        do_reset();

        // single add
        set_req(0, 10, 15, 3'b000);
        wait_hs(0);
        chk("add_res", h_res, 25);
        chk("add_zero", 32'(h_zero), 0);
        cycle();
        chk("add_idle", 32'(busy), 0);

        // contention after reset
        do_reset();
        set_req(0, 20, 8, 3'b001);
        set_req(1, 7, 6, 3'b011);
        wait_hs(0);
        chk("sub_res", h_res, 12);
        wait_hs(1);
        chk("mul_res", h_res, 42);
        set_req(0, 1, 2, 3'b000);
        set_req(1, 3, 4, 3'b000);
        wait_hs(0);
        chk("rr_res0", h_res, 3);
        wait_hs(1);
        chk("rr_res1", h_res, 7);

        // div latency
        set_req(1, 40, 5, 3'b010);
        wait_hs(1);
        chk("div_res", h_res, 8);

        // divide by zero under backpressure, req1 waiting
        d_rdy[0] = 0;
        set_req(0, 100, 0, 3'b010);
        set_req(1, 3, 4, 3'b000);
        for (int i = 0; i < 20 && !(m_act && m_rem == 0); i++) cycle();
        chk("dz_reached", 32'(m_act && m_rem == 0), 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("dz_hold", rsp0_result, 32'hFFFF_FFFF);
            chk("dz_valid", 32'(rsp0_valid), 1);
        end
        d_rdy[0] = 1;
        wait_hs(0);
        chk("dz_res", h_res, 32'hFFFF_FFFF);
        cycle();
        chk("dz_next_grant", 32'(g_evt && g_who), 1);
        wait_hs(1);

        // zero flag, then reset in the middle of a div
        set_req(0, 50, 50, 3'b001);
        wait_hs(0);
        chk("z_res", h_res, 0);
        chk("z_flag", 32'(h_zero), 1);
        set_req(0, 9, 3, 3'b010);
        for (int i = 0; i < 10 && !g_evt; i++) cycle();
        chk("div_acc", 32'(g_evt), 1);
        cycle();
        do_reset();
        repeat (8) cycle();
        set_req(1, 1, 1, 3'b000);
        wait_hs(1);
        chk("post_rst_res", h_res, 2);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int w = 0; w < 2; w++) begin
                if (!d_pend[w]) begin
                    d_a[w]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
                    d_b[w]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
                    d_op[w] = 3'($urandom_range(0, 7));
                    d_pend[w] = ($urandom_range(0, 2) != 0);
                end
                d_rdy[w] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        d_pend[0] = 0; d_pend[1] = 0; d_rdy[0] = 1; d_rdy[1] = 1;
        repeat (10) cycle();
        chk("drain_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Sequencer and arbiter that shares the single combinational ALU (rs1/rs2/op_ctrl in; alu_op/b_zero out) between two requesters, e.g. the execute stage and a CSR/debug unit. It accepts one operation at a time with valid/ready handshakes and uses round-robin priority. It holds the ALU operands stable for an op-dependent number of cycles so that MUL/DIV paths can settle. It then returns the registered result on a per-requester response channel.

Parameters:
XLEN, 32, operand/result width
MUL_CYCLES, 2, EXEC cycles for op_ctrl=3'b011 (legal range >=1)
DIV_CYCLES, 4, EXEC cycles for op_ctrl=3'b010 (legal range >=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req0_valid / req1_valid  input  1  requester N has an operation
req0_ready / req1_ready  output  1  operation from requester N accepted this cycle
req0_rs1 / req1_rs1  input  XLEN  operand A
req0_rs2 / req1_rs2  input  XLEN  operand B
req0_op / req1_op  input  3  op_ctrl: 000 add, 001 sub, 010 div, 011 mul
rsp0_valid / rsp1_valid  output  1  result available for requester N
rsp0_ready / rsp1_ready  input  1  requester N consumes result
rsp0_result / rsp1_result  output  XLEN  result (shared register, valid only with rspN_valid)
rsp0_zero / rsp1_zero  output  1  captured zero flag
alu_rs1  output  XLEN  to ALU rs1
alu_rs2  output  XLEN  to ALU rs2
alu_op_ctrl  output  3  to ALU op_ctrl
alu_result  input  XLEN  from ALU alu_op
alu_zero  input  1  from ALU b_zero
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: state=IDLE; all reqN_ready, rspN_valid and busy are 0.
  - Registers: alu_rs1, alu_rs2, alu_op_ctrl, result and zero registers are 0; cnt=0; prio=0 (req0 favoured); owner=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and is 1 only for the winner.
  - Winner selection: the single valid requester wins. If both are valid, requester `prio` wins.
  - On the accepting edge, latch rs1/rs2/op into the alu_* registers and latch owner.
  - Load cnt = DIV_CYCLES for div, MUL_CYCLES for mul, and 1 for all other codes. Go to EXEC.
  - No requester is valid: stay in IDLE.
- EXEC:
  - alu_* are held constant.
  - cnt>1: cnt decrements each cycle.
  - cnt==1: on that edge, capture alu_result and alu_zero into the result registers and go to RESP.
- RESP:
  - rsp[owner]_valid=1; the other rsp valid stays 0.
  - Handshake (rsp[owner]_ready=1): go to IDLE and set prio = ~owner.
  - rsp[owner]_ready=0: hold state; valid, result and zero stay stable indefinitely (backpressure).
- No new request is accepted in RESP or EXEC, and no accept happens in the same cycle as a response handshake.
- Latency, with the accept edge as edge 0: rsp_valid rises after edge `lat`, where lat = 1 (add/sub), MUL_CYCLES or DIV_CYCLES. Best-case issue rate is one op per lat+2 cycles.
- Codes 1xx are passed through to the ALU unchanged with latency 1. The result is whatever the ALU drives; no error flag is raised.
- Division by zero is not special-cased: the ALU's 32'hFFFFFFFF and its zero flag are passed through as returned.
- alu_* keep the last latched values in IDLE/RESP; they are not cleared.
- cnt width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- Requester inputs are sampled only on the accepting edge. Changes afterward do not affect the op in flight.
- rst_n asserted mid-EXEC or mid-RESP discards the op; no response is ever issued for it.

Test Plan:
- Single ADD: req0 valid with rs1=10, rs2=15, op=000, rsp0_ready=1. Required: req0_ready=1 for one cycle; rsp0_valid after 1 EXEC cycle; result=25, zero=0; busy returns to 0.
- Contention after reset: both requesters valid simultaneously (req0 SUB 20-8, req1 MUL 7*6). Required:
  - req0 is granted first; its response is result=12.
  - req1 is granted next; rsp1_valid comes after 2 EXEC cycles; result=42.
  - Then, with both valid again, req0 wins (prio back to 0 after req1 completes).
- DIV latency: req1 sends 40/5, op=010. Required: alu_* are stable for exactly 4 cycles; rsp1_valid rises after the 4th EXEC edge; result=8.
- Divide by zero plus backpressure: req0 sends 100/0, rsp0_ready held low for 5 cycles. Required:
  - rsp0_valid holds with result=32'hFFFFFFFF, stable for all 5 cycles.
  - req1 stays valid throughout but is not granted until the cycle after the rsp0 handshake.
- Zero flag and reset: SUB 50-50 returns result=0, zero=1. Then start a DIV, pull rst_n low in the 2nd EXEC cycle, release, and issue a new req1 ADD 1+1. Required:
  - Outputs clear immediately on rst_n low.
  - No rsp is issued for the DIV.
  - The new op returns result=2.
